// File: rtl/encrypt_stream_unit_pkg.sv
`default_nettype none
// ============================================================================
// encrypt_stream_unit_pkg : shared permutation, key selector and config types
// Revision: 1.0
// ============================================================================
package encrypt_stream_unit_pkg;

    // Output bit i of the permute stage is taken from input bit PERM_i
    localparam logic [2:0] PERM_0 = 3'd3;
    localparam logic [2:0] PERM_1 = 3'd6;
    localparam logic [2:0] PERM_2 = 3'd1;
    localparam logic [2:0] PERM_3 = 3'd4;
    localparam logic [2:0] PERM_4 = 3'd7;
    localparam logic [2:0] PERM_5 = 3'd2;
    localparam logic [2:0] PERM_6 = 3'd5;
    localparam logic [2:0] PERM_7 = 3'd0;

    typedef enum logic [1:0] {
        KEY1 = 2'd0,
        KEY2 = 2'd1,
        KEY3 = 2'd2
    } key_sel_t;

    typedef struct packed {
        logic [7:0] k1;
        logic [7:0] k2;
        logic [7:0] k3;
        logic [2:0] rot_freq;
        logic       shift_en;
        logic [2:0] shift_amt;
        logic       mode;
    } enc_cfg_t;

    // KEY3 -> KEY1 -> KEY2 -> KEY3 keeps step with the decrypt key register
    function automatic key_sel_t next_key_sel(input key_sel_t sel);
        key_sel_t nxt;
        case (sel)
            KEY3:    nxt = KEY1;
            KEY1:    nxt = KEY2;
            default: nxt = KEY3;
        endcase
        return nxt;
    endfunction

    function automatic logic [7:0] permute_byte(input logic [7:0] b);
        return {b[PERM_7], b[PERM_6], b[PERM_5], b[PERM_4],
                b[PERM_3], b[PERM_2], b[PERM_1], b[PERM_0]};
    endfunction

endpackage
`default_nettype wire

// File: rtl/encrypt_stream_unit_if.sv
`default_nettype none
// ============================================================================
// encrypt_stream_unit_if : byte stream, config and output handshake bundle
// Revision: 1.0
// ============================================================================
interface encrypt_stream_unit_if;
    logic [7:0] din;
    logic       en;
    logic       rdy;
    logic [7:0] k1;
    logic [7:0] k2;
    logic [7:0] k3;
    logic [2:0] rot_freq;
    logic       shift_en;
    logic [2:0] shift_amt;
    logic       mode;
    logic       key_load;
    logic [7:0] dout;
    logic       v;
    logic       out_ready;

    modport master (
        output din, en, k1, k2, k3, rot_freq, shift_en, shift_amt, mode, key_load, out_ready,
        input  rdy, dout, v
    );

    modport slave (
        input  din, en, k1, k2, k3, rot_freq, shift_en, shift_amt, mode, key_load, out_ready,
        output rdy, dout, v
    );
endinterface
`default_nettype wire

// File: rtl/encrypt_stream_unit_out_buf.sv
`default_nettype none
// ============================================================================
// encrypt_stream_unit_out_buf : small elastic buffer, head/tail ring pointers
// Revision: 1.0
// ============================================================================
module encrypt_stream_unit_out_buf #(
    parameter  int DEPTH = 2,
    parameter  int WIDTH = 8,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] cnt
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_cnt;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Guard against overflow/underflow so a misbehaving caller cannot corrupt the count
    assign w_push = push && (r_cnt != CNT_W'(DEPTH));
    assign w_pop  = pop  && (r_cnt != '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head <= '0;
            r_tail <= '0;
            r_cnt  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_tail] <= push_data;
                r_tail        <= wrap_inc(r_tail);
            end
            if (w_pop) begin
                r_head <= wrap_inc(r_head);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + 1'b1;
                2'b01:   r_cnt <= r_cnt - 1'b1;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    assign head = r_mem[r_head];
    assign cnt  = r_cnt;

endmodule
`default_nettype wire

// File: rtl/encrypt_stream_unit.sv
`default_nettype none
// ============================================================================
// encrypt_stream_unit : permute -> rotate -> rotating-key XOR byte encryptor
// Revision: 1.0
// ============================================================================
module encrypt_stream_unit
    import encrypt_stream_unit_pkg::*;
#(
    parameter int         BUF_DEPTH     = 2,
    parameter logic [2:0] INIT_ROT_FREQ = 3'd0
) (
    input  logic                 clk,
    input  logic                 rst,
    encrypt_stream_unit_if.slave bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH + 1);

    enc_cfg_t   r_cfg;
    enc_cfg_t   w_cfg;
    key_sel_t   r_key_sel;
    key_sel_t   w_key_sel;
    logic [2:0] r_rot_cnt;
    logic [2:0] w_rot_cnt;

    logic       r_s1_v;
    logic [7:0] r_s1_data;
    logic [7:0] r_s1_key;
    logic       r_s1_mode;
    logic       r_s1_shift_en;
    logic [2:0] r_s1_shift_amt;

    logic             w_rdy;
    logic             w_accept;
    logic             w_move;
    logic             w_v;
    logic             w_pop;
    logic [7:0]       w_key_byte;
    logic [7:0]       w_perm;
    logic [7:0]       w_rot;
    logic [7:0]       w_cipher;
    logic [7:0]       w_head;
    logic [CNT_W-1:0] w_buf_cnt;

    // A key_load takes effect for a byte accepted on the same edge
    always_comb begin
        w_cfg     = r_cfg;
        w_key_sel = r_key_sel;
        w_rot_cnt = r_rot_cnt;
        if (bus.key_load) begin
            w_cfg = '{k1:        bus.k1,
                      k2:        bus.k2,
                      k3:        bus.k3,
                      rot_freq:  bus.rot_freq,
                      shift_en:  bus.shift_en,
                      shift_amt: bus.shift_amt,
                      mode:      bus.mode};
            w_key_sel = KEY3;
            w_rot_cnt = '0;
        end
    end

    always_comb begin
        w_key_byte = w_cfg.k3;
        case (w_key_sel)
            KEY1:    w_key_byte = w_cfg.k1;
            KEY2:    w_key_byte = w_cfg.k2;
            default: w_key_byte = w_cfg.k3;
        endcase
    end

    assign w_v      = (w_buf_cnt != '0);
    assign w_pop    = w_v && bus.out_ready;
    // A full buffer blocks the transfer even when a pop frees a slot this cycle
    assign w_move   = r_s1_v && (w_buf_cnt < CNT_W'(BUF_DEPTH));
    assign w_rdy    = !r_s1_v || (w_buf_cnt < CNT_W'(BUF_DEPTH));
    assign w_accept = bus.en && w_rdy;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cfg     <= '{k1: 8'h00, k2: 8'h00, k3: 8'h00, rot_freq: INIT_ROT_FREQ,
                           shift_en: 1'b0, shift_amt: 3'd0, mode: 1'b0};
            r_key_sel <= KEY3;
            r_rot_cnt <= '0;
        end else begin
            r_cfg <= w_cfg;
            if (w_accept && (w_rot_cnt == w_cfg.rot_freq)) begin
                r_key_sel <= next_key_sel(w_key_sel);
                r_rot_cnt <= '0;
            end else if (w_accept) begin
                r_key_sel <= w_key_sel;
                r_rot_cnt <= w_rot_cnt + 3'd1;
            end else begin
                r_key_sel <= w_key_sel;
                r_rot_cnt <= w_rot_cnt;
            end
        end
    end

    // Stage 1 snapshots the transform settings so in-flight bytes keep their encryption
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_s1_v         <= 1'b0;
            r_s1_data      <= '0;
            r_s1_key       <= '0;
            r_s1_mode      <= 1'b0;
            r_s1_shift_en  <= 1'b0;
            r_s1_shift_amt <= '0;
        end else if (w_accept) begin
            r_s1_v         <= 1'b1;
            r_s1_data      <= bus.din;
            r_s1_key       <= w_key_byte;
            r_s1_mode      <= w_cfg.mode;
            r_s1_shift_en  <= w_cfg.shift_en;
            r_s1_shift_amt <= w_cfg.shift_amt;
        end else if (w_move) begin
            r_s1_v <= 1'b0;
        end
    end

    assign w_perm   = r_s1_mode ? permute_byte(r_s1_data) : r_s1_data;
    assign w_rot    = r_s1_shift_en
                    ? ((w_perm << r_s1_shift_amt) | (w_perm >> (4'd8 - {1'b0, r_s1_shift_amt})))
                    : w_perm;
    assign w_cipher = w_rot ^ r_s1_key;

    encrypt_stream_unit_out_buf #(
        .DEPTH (BUF_DEPTH),
        .WIDTH (8)
    ) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .push      (w_move),
        .push_data (w_cipher),
        .pop       (w_pop),
        .head      (w_head),
        .cnt       (w_buf_cnt)
    );

    assign bus.rdy  = w_rdy;
    assign bus.v    = w_v;
    assign bus.dout = w_head;

endmodule
`default_nettype wire

// File: doc/encrypt_stream_unit.md
Name: encrypt_stream_unit

Overview:
Configurable-mode byte encryptor that produces the stream decrypt_pipe / decrypt_unit invert.
- Datapath order: permute (optional), then rotate (optional), then XOR with a rotating 3-byte key.
- Adds a valid/ready handshake on both sides and a 2-entry output buffer, so it can sit between a byte source and a backpressuring sink (link or FIFO).
- Key order and rotation match the decrypt side exactly.

Parameters:
- BUF_DEPTH, 2, output buffer entries; only 2 is supported.
- INIT_ROT_FREQ, 3'd0, rotation frequency loaded at reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- din  in  8  plaintext byte.
- en  in  1  din valid.
- rdy  out  1  unit can accept a byte; depends on registered state only.
- k1, k2, k3  in  8 each  key bytes; captured on key_load.
- rot_freq  in  3  captured on key_load; key rotates every rot_freq+1 accepted bytes.
- shift_en  in  1  captured on key_load; enables the data rotate.
- shift_amt  in  3  captured on key_load; rotate-left amount.
- mode  in  1  captured on key_load; 1 = apply `PERM permutation, 0 = bypass.
- key_load  in  1  pulse: capture config, reset key pointer and rotation counter.
- dout  out  8  ciphertext byte.
- v  out  1  dout valid.
- out_ready  in  1  sink accepts dout this cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - rdy=1 once reset is released; dout=0; v=0; buffer empty; stage-1 register empty.
  - Config: keys=0, rot_freq=INIT_ROT_FREQ, shift_en=0, mode=0.
  - Key pointer=KEY3, rotation counter=0.
  - Reset mid-stream discards all in-flight bytes, with no partial output.
- Accept: a byte is accepted on an edge where en=1 and rdy=1. en while rdy=0 is ignored; the source must hold the byte.
- rdy = !s1_v || (buf_cnt < 2).
- Stage 1 (input register):
  - Holds the raw byte plus the key byte selected at acceptance.
  - Key pointer sequence: KEY3, KEY1, KEY2, KEY3, ... This matches the decrypt initial key {K2,K3,K1} using bits [15:8].
- Key rotation:
  - The rotation counter increments per accepted byte.
  - When counter==rot_freq on an accepted byte, the pointer advances and the counter returns to 0.
  - No accepted byte means no change.
- Datapath, computed between stage 1 and the buffer:
  - p[i] = mode ? s1[`PERM_i] : s1[i].
  - r = shift_en ? p rotated left by shift_amt : p. shift_amt=0 leaves the byte unchanged.
  - dout_next = r ^ key.
- Stage 1 to buffer transfer:
  - Moves when s1_v=1 and buf_cnt<2.
  - When buf_cnt==2, it does not move, even if a pop occurs in the same cycle.
- Output:
  - v = (buf_cnt != 0); dout = buffer head.
  - A pop occurs on an edge with v=1 and out_ready=1.
  - Push and pop in the same cycle leave buf_cnt unchanged.
  - dout and v are stable while v=1 and out_ready=0.
- Latency and throughput:
  - An accept at edge N gives v=1 after edge N+1.
  - Sustained 1 byte/cycle while out_ready=1.
- key_load:
  - Captures config and resets the pointer to KEY3 and the counter to 0.
  - A byte accepted on the same edge uses the new config and key KEY3 (new k3).
  - Bytes already in stage 1 or the buffer keep their old encryption.
- Ciphertext is identical to the decrypt path when both sides share config and key_load alignment.

Decomposition:
- Package encrypt_config (shared) holds:
  - `PERM_0..7 constants.
  - typedef enum key_sel_t {KEY1, KEY2, KEY3}.
  - typedef struct enc_cfg_t {k1, k2, k3, rot_freq, shift_en, shift_amt, mode}.
  - function next_key_sel().
- Sub-module encrypt_out_buf: 2-entry elastic buffer.
  - Ports: push, push_data, pop, head, cnt.
  - Head/tail pointers with wrap-around.

Test Plan:
- No permutation or rotate: mode=0, shift_en=0, k1=0x11, k2=0x22, k3=0x33, rot_freq=0, key_load. Four accepted 0x00 bytes -> dout 0x33, 0x11, 0x22, 0x33; first v one cycle after the accept edge.
- Slower rotation: same config with rot_freq=1, six 0x00 bytes -> 0x33, 0x33, 0x11, 0x11, 0x22, 0x22.
- Rotate only: keys=0, mode=0, shift_en=1, shift_amt=1, din=0x81 -> 0x03. Then shift_amt=0, din=0x81 -> 0x81.
- Backpressure: out_ready=0 while streaming 0x01..0x05 -> buffer fills; rdy=0 after 3 accepted bytes; dout held at the first byte. Release -> all bytes emitted in order, none lost or duplicated.
- key_load mid-stream: load new k3=0xA5 on the edge accepting byte 0x00 -> that byte emits 0xA5; earlier in-flight bytes keep old keys.
- Reset and round trip: assert rst with 2 bytes buffered -> v=0, dout=0 immediately. Then 256 random bytes with random config fed through decrypt_pipe -> recovered bytes equal the input.
